// File: rtl/mapu_mstream_tp_pkg.sv
// Shared types for the Matrix Stream 3x3 transposer: index type, bank storage type, index helpers.
package mapu_mstream_tp_pkg;

  localparam int MSTREAM_ROWS   = 3;
  localparam int MSTREAM_MAX_DW = 32;

  typedef logic [1:0] idx_t;

  // Indexed [row][col]; elements narrower than the max width sit in the low bits.
  typedef logic [MSTREAM_ROWS-1:0][MSTREAM_ROWS-1:0][MSTREAM_MAX_DW-1:0] bank_t;

  function automatic logic idx_last(input idx_t i);
    return i == idx_t'(MSTREAM_ROWS - 1);
  endfunction

  function automatic idx_t idx_next(input idx_t i);
    return idx_last(i) ? idx_t'(0) : i + idx_t'(1);
  endfunction

endpackage

// File: rtl/mapu_mstream_tp_bank.sv
// One 3x3 register bank: column-wide write port, row-wide read port and a full flag.
module mapu_mstream_tp_bank
  import mapu_mstream_tp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    we,
  input  idx_t                                    col,
  input  logic [MSTREAM_ROWS-1:0][DATA_WIDTH-1:0] wcol,
  input  idx_t                                    row,
  output logic [MSTREAM_ROWS-1:0][DATA_WIDTH-1:0] rrow,
  input  logic                                    full_set,
  input  logic                                    full_clr,
  output logic                                    full
);

  bank_t mem_reg;
  logic  full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg  <= '0;
      full_reg <= 1'b0;
    end else begin
      if (we) begin
        for (int r = 0; r < MSTREAM_ROWS; r++) begin
          mem_reg[r][col] <= MSTREAM_MAX_DW'(wcol[r]);
        end
      end
      // The top never sets and clears the same bank in one cycle; set wins if it did.
      if (full_set) begin
        full_reg <= 1'b1;
      end else if (full_clr) begin
        full_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rrow = '0;
    for (int c = 0; c < MSTREAM_ROWS; c++) begin
      rrow[c] = mem_reg[row][c][DATA_WIDTH-1:0];
    end
  end

  assign full = full_reg;

endmodule

// File: rtl/mapu_mstream_transposer.sv
// Ping-pong 3x3 transposer: columns in, rows out, one beat per cycle each way.
// Optional MAPU_MSTREAM_TRANSPOSER_STATS_EN adds the mtx_cnt completed-matrix counter.
module mapu_mstream_transposer
  import mapu_mstream_tp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  ig_vld,
  output logic                  ig_rdy,
  input  logic [DATA_WIDTH-1:0] ig_r0,
  input  logic [DATA_WIDTH-1:0] ig_r1,
  input  logic [DATA_WIDTH-1:0] ig_r2,
  output logic                  eg_vld,
  input  logic                  eg_rdy,
  output logic [DATA_WIDTH-1:0] eg_r0,
  output logic [DATA_WIDTH-1:0] eg_r1,
  output logic [DATA_WIDTH-1:0] eg_r2
`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
  ,
  output logic [15:0]           mtx_cnt
`endif
);

  logic wr_sel_reg;
  idx_t wr_col_reg;
  logic rd_sel_reg;
  idx_t rd_row_reg;

  logic [1:0]                                    full;
  logic [1:0][MSTREAM_ROWS-1:0][DATA_WIDTH-1:0] rrow;
  logic ig_fire;
  logic eg_fire;
  logic wr_last;
  logic rd_last;

  // Ready comes only from the full flags, so eg_rdy never reaches ig_rdy combinationally.
  assign ig_rdy  = !full[wr_sel_reg];
  assign eg_vld  = full[rd_sel_reg];
  assign ig_fire = ig_vld && ig_rdy;
  assign eg_fire = eg_vld && eg_rdy;
  assign wr_last = ig_fire && idx_last(wr_col_reg);
  assign rd_last = eg_fire && idx_last(rd_row_reg);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      mapu_mstream_tp_bank #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_bank (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .we       (ig_fire && (wr_sel_reg == 1'(gi))),
        .col      (wr_col_reg),
        .wcol     ({ig_r2, ig_r1, ig_r0}),
        .row      (rd_row_reg),
        .rrow     (rrow[gi]),
        .full_set (wr_last && (wr_sel_reg == 1'(gi))),
        .full_clr (rd_last && (rd_sel_reg == 1'(gi))),
        .full     (full[gi])
      );
    end
  endgenerate

  assign eg_r0 = rrow[rd_sel_reg][0];
  assign eg_r1 = rrow[rd_sel_reg][1];
  assign eg_r2 = rrow[rd_sel_reg][2];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_reg <= 1'b0;
      wr_col_reg <= '0;
      rd_sel_reg <= 1'b0;
      rd_row_reg <= '0;
    end else begin
      if (ig_fire) begin
        wr_col_reg <= idx_next(wr_col_reg);
        if (wr_last) wr_sel_reg <= !wr_sel_reg;
      end
      if (eg_fire) begin
        rd_row_reg <= idx_next(rd_row_reg);
        if (rd_last) rd_sel_reg <= !rd_sel_reg;
      end
    end
  end

`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (rd_last) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign mtx_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_mapu_mstream_transposer.sv
// Directed bench for mapu_mstream_transposer: vector table plus hand-written corner sequences.
module tb_mapu_mstream_transposer;

  localparam int DW = 32;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ig_vld  = 1'b0;
  logic          ig_rdy;
  logic [DW-1:0] ig_r0 = '0, ig_r1 = '0, ig_r2 = '0;
  logic          eg_vld;
  logic          eg_rdy = 1'b0;
  logic [DW-1:0] eg_r0, eg_r1, eg_r2;
`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
  logic [15:0]   mtx_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  mapu_mstream_transposer #(.DATA_WIDTH(DW)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .ig_vld  (ig_vld),
    .ig_rdy  (ig_rdy),
    .ig_r0   (ig_r0),
    .ig_r1   (ig_r1),
    .ig_r2   (ig_r2),
    .eg_vld  (eg_vld),
    .eg_rdy  (eg_rdy),
    .eg_r0   (eg_r0),
    .eg_r1   (eg_r1),
    .eg_r2   (eg_r2)
`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
    ,
    .mtx_cnt (mtx_cnt)
`endif
  );

  typedef struct {
    logic [3*DW-1:0] col [3];   // ingress beats {r0,r1,r2}
    logic [3*DW-1:0] row [3];   // expected egress beats {r0,r1,r2}
  } vec_t;

  vec_t            vecs [4];
  logic [3*DW-1:0] in_q  [$];
  logic [3*DW-1:0] out_q [$];
  logic [3*DW-1:0] exp_q [$];
  int              tests = 0;
  int              fails = 0;

  function automatic logic [3*DW-1:0] b3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return {a, b, c};
  endfunction

  // Element A[r][c] of generated matrix m.
  function automatic logic [DW-1:0] elem(input int m, input int r, input int c);
    return DW'((m + 1) * 256 + r * 16 + c);
  endfunction

  task automatic check(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    ig_vld  = 1'b0;
    eg_rdy  = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
  endtask

  // Drives in_q with the given vld/rdy probabilities until n_out egress beats are collected.
  task automatic run_stream(input int ig_pct, input int eg_pct, input int n_out,
                            input int max_cycles, output int stalls);
    int   got = 0;
    int   cyc = 0;
    logic fire;
    stalls = 0;
    while (got < n_out && cyc < max_cycles) begin
      if (!ig_vld && in_q.size() > 0 && int'($urandom_range(99)) < ig_pct) begin
        ig_vld = 1'b1;
        {ig_r0, ig_r1, ig_r2} = in_q[0];
      end
      eg_rdy = int'($urandom_range(99)) < eg_pct;
      @(negedge sys_clk);
      fire = ig_vld && ig_rdy;
      if (ig_vld && !ig_rdy) stalls++;
      if (eg_vld && eg_rdy) begin
        out_q.push_back({eg_r0, eg_r1, eg_r2});
        got++;
      end
      @(posedge sys_clk);
      #1;
      if (fire) begin
        void'(in_q.pop_front());
        ig_vld = 1'b0;
      end
      cyc++;
    end
    ig_vld = 1'b0;
    eg_rdy = 1'b0;
    check("stream_beats", 96'(got), 96'(n_out));
  endtask

  task automatic check_out(input string tag);
    check({tag, "_count"}, 96'(out_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic push_matrix(input int m);
    for (int j = 0; j < 3; j++) in_q.push_back(b3(elem(m, 0, j), elem(m, 1, j), elem(m, 2, j)));
    for (int k = 0; k < 3; k++) exp_q.push_back(b3(elem(m, k, 0), elem(m, k, 1), elem(m, k, 2)));
  endtask

  initial begin
    int stalls;
    int idx;
    int first_low;
    logic fire;
    logic [3*DW-1:0] bp_beat [9];
    logic [DW-1:0] a [3][3];

    vecs[0].col = '{b3(1, 4, 7), b3(2, 5, 8), b3(3, 6, 9)};
    vecs[0].row = '{b3(1, 2, 3), b3(4, 5, 6), b3(7, 8, 9)};
    vecs[1].col = '{b3('1, 0, 0), b3(0, '1, 0), b3(0, 0, '1)};
    vecs[1].row = '{b3('1, 0, 0), b3(0, '1, 0), b3(0, 0, '1)};
    vecs[2].col = '{b3(32'hA, 32'hB, 32'hC), b3(32'hD, 32'hE, 32'hF), b3(32'h10, 32'h11, 32'h12)};
    vecs[2].row = '{b3(32'hA, 32'hD, 32'h10), b3(32'hB, 32'hE, 32'h11), b3(32'hC, 32'hF, 32'h12)};
    vecs[3].col = '{b3(32'hDEADBEEF, 32'h12345678, 0), b3(32'h80000000, 1, 32'h7FFFFFFF),
                    b3(32'hCAFEF00D, 0, 32'hFFFFFFFF)};
    vecs[3].row = '{b3(32'hDEADBEEF, 32'h80000000, 32'hCAFEF00D), b3(32'h12345678, 1, 0),
                    b3(0, 32'h7FFFFFFF, 32'hFFFFFFFF)};

    // Reset values
    reset_dut();
    @(negedge sys_clk);
    check("rst_ig_rdy", 96'(ig_rdy), 96'(1));
    check("rst_eg_vld", 96'(eg_vld), 96'(0));
    check("rst_eg_data", {eg_r0, eg_r1, eg_r2}, '0);
`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
    check("rst_mtx_cnt", 96'(mtx_cnt), 96'(0));
`endif
    @(posedge sys_clk);
    #1;

    // Latency: eg_vld low through the three accepts, high one cycle after the third
    eg_rdy = 1'b1;
    ig_vld = 1'b1;
    for (int j = 0; j < 3; j++) begin
      {ig_r0, ig_r1, ig_r2} = vecs[0].col[j];
      @(negedge sys_clk);
      check($sformatf("lat_ig_rdy%0d", j), 96'(ig_rdy), 96'(1));
      check($sformatf("lat_eg_vld_low%0d", j), 96'(eg_vld), 96'(0));
      @(posedge sys_clk);
      #1;
    end
    ig_vld = 1'b0;
    @(negedge sys_clk);
    check("lat_eg_vld_high", 96'(eg_vld), 96'(1));
    check("lat_row0", {eg_r0, eg_r1, eg_r2}, vecs[0].row[0]);
    @(posedge sys_clk);
    #1;
    exp_q.push_back(vecs[0].row[1]);
    exp_q.push_back(vecs[0].row[2]);
    run_stream(100, 100, 2, 20, stalls);
    check_out("lat_tail");

    // Table-driven single matrices
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 3; j++) begin
        in_q.push_back(vecs[v].col[j]);
        exp_q.push_back(vecs[v].row[j]);
      end
      run_stream(100, 100, 3, 40, stalls);
      check_out($sformatf("vec%0d", v));
    end

    // Back-to-back streaming of 8 matrices
    reset_dut();
    for (int m = 0; m < 8; m++) push_matrix(m + 3);
    run_stream(100, 100, 24, 200, stalls);
    check("stream_no_stall", 96'(stalls), 96'(0));
    check_out("stream");
`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
    check("stream_mtx_cnt", 96'(mtx_cnt), 96'(8));
`endif

    // Backpressure: both banks fill, then one bank drains
    reset_dut();
    for (int m = 0; m < 3; m++)
      for (int j = 0; j < 3; j++) bp_beat[m * 3 + j] = b3(elem(m, 0, j), elem(m, 1, j), elem(m, 2, j));
    idx = 0;
    first_low = -1;
    ig_vld = 1'b1;
    {ig_r0, ig_r1, ig_r2} = bp_beat[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (!ig_rdy && first_low < 0) first_low = c;
      fire = ig_rdy;
      @(posedge sys_clk);
      #1;
      if (fire) begin
        idx++;
        {ig_r0, ig_r1, ig_r2} = bp_beat[idx];
      end
    end
    check("bp_accepted", 96'(idx), 96'(6));
    check("bp_rdy_low_cycle", 96'(first_low), 96'(6));
    eg_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      check($sformatf("bp_drain_vld%0d", k), 96'(eg_vld), 96'(1));
      check($sformatf("bp_drain_row%0d", k), {eg_r0, eg_r1, eg_r2},
            b3(elem(0, k, 0), elem(0, k, 1), elem(0, k, 2)));
      check($sformatf("bp_drain_rdy%0d", k), 96'(ig_rdy), 96'(0));
      @(posedge sys_clk);
      #1;
    end
    eg_rdy = 1'b0;
    @(negedge sys_clk);
    check("bp_rdy_back", 96'(ig_rdy), 96'(1));
    check("bp_eg_vld_other_bank", 96'(eg_vld), 96'(1));
    @(posedge sys_clk);
    #1;
    ig_vld = 1'b0;
    in_q.push_back(bp_beat[7]);
    in_q.push_back(bp_beat[8]);
    for (int m = 1; m < 3; m++)
      for (int k = 0; k < 3; k++) exp_q.push_back(b3(elem(m, k, 0), elem(m, k, 1), elem(m, k, 2)));
    run_stream(100, 100, 6, 50, stalls);
    check_out("bp_tail");

    // Random vld/rdy over 100 random matrices
    reset_dut();
    for (int m = 0; m < 100; m++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) a[r][c] = $urandom;
      for (int j = 0; j < 3; j++) in_q.push_back(b3(a[0][j], a[1][j], a[2][j]));
      for (int k = 0; k < 3; k++) exp_q.push_back(b3(a[k][0], a[k][1], a[k][2]));
    end
    run_stream(50, 50, 300, 8000, stalls);
    check_out("rand");
`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
    check("rand_mtx_cnt", 96'(mtx_cnt), 96'(100));
`endif

    // Reset in the middle of a matrix
    reset_dut();
    eg_rdy = 1'b0;
    ig_vld = 1'b1;
    {ig_r0, ig_r1, ig_r2} = b3(32'h11, 32'h22, 32'h33);
    @(posedge sys_clk);
    #1;
    {ig_r0, ig_r1, ig_r2} = b3(32'h44, 32'h55, 32'h66);
    @(posedge sys_clk);
    #1;
    ig_vld  = 1'b0;
    reset_n = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_ig_rdy", 96'(ig_rdy), 96'(1));
    check("mid_rst_eg_vld", 96'(eg_vld), 96'(0));
    check("mid_rst_eg_data", {eg_r0, eg_r1, eg_r2}, '0);
    @(posedge sys_clk);
    #1 reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_q.push_back(vecs[3].col[j]);
      exp_q.push_back(vecs[3].row[j]);
    end
    run_stream(100, 100, 3, 40, stalls);
    check_out("mid_rst");
    @(negedge sys_clk);
    check("mid_rst_idle", 96'(eg_vld), 96'(0));
    @(posedge sys_clk);
    #1;

`ifdef MAPU_MSTREAM_TRANSPOSER_STATS_EN
    // Counter wrap
    reset_dut();
    @(negedge sys_clk);
    force dut.cnt_reg = 16'hFFFF;
    @(posedge sys_clk);
    #1 release dut.cnt_reg;
    for (int j = 0; j < 3; j++) begin
      in_q.push_back(vecs[0].col[j]);
      exp_q.push_back(vecs[0].row[j]);
    end
    run_stream(100, 100, 3, 40, stalls);
    check_out("wrap");
    check("wrap_mtx_cnt", 96'(mtx_cnt), 96'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mapu_mstream_transposer.md
# mapu_mstream_transposer

Transposes 3x3 matrices carried on the Matrix Stream protocol. Each ingress beat is one matrix column (rows r0..r2); each egress beat is one matrix row. Sits between the Matrix Stream ingress port and the MAPU compute core. Ping-pong buffering sustains one beat per cycle in steady state.

## Interface
- DATA_WIDTH, 32, width of each matrix element (one row lane)
- sys_clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ig_vld  in  1  ingress beat valid
- ig_rdy  out  1  ingress ready
- ig_r0 / ig_r1 / ig_r2  in  DATA_WIDTH each  ingress column elements A[0][j], A[1][j], A[2][j]
- eg_vld  out  1  egress beat valid
- eg_rdy  in  1  egress ready
- eg_r0 / eg_r1 / eg_r2  out  DATA_WIDTH each  egress elements A[k][0], A[k][1], A[k][2] for beat k
- mtx_cnt  out  16  completed output matrices (only with MAPU_MSTREAM_TRANSPOSER_STATS_EN)

## Operation
- Handshake: transfer when vld && rdy on a rising edge. The sender holds vld and data stable until transfer. rdy may toggle freely.
- Storage: two 3x3 banks (bank 0, bank 1), each with a full flag.
- Write side: wr_sel (1 bit) and wr_col (0..2).
  - Each accepted ingress beat writes column wr_col of bank wr_sel.
  - On wr_col==2 accept: set full[wr_sel], toggle wr_sel, wr_col←0. Otherwise wr_col increments.
- Read side: rd_sel (1 bit) and rd_row (0..2).
  - eg_vld = full[rd_sel].
  - eg_rN = bank[rd_sel][rd_row][N].
  - On each egress transfer, rd_row increments. On rd_row==2 transfer: clear full[rd_sel], toggle rd_sel, rd_row←0.
- ig_rdy = !full[wr_sel]. It is derived from registered state only, with no combinational path from eg_rdy.
- Egress data come from storage registers. eg_r* is don't-care when eg_vld=0, but it must not be X after reset: banks reset to 0.
- Simultaneous events:
  - The last write of one bank and the last read of the other bank in the same cycle are both honoured.
  - The full flags of different banks update independently.
- Both banks full with ig_vld held: ig_rdy=0 until the read side frees a bank. The freed bank shows ig_rdy=1 on the following cycle.
- Reset mid-operation discards any partially written or partially read matrix.

## Timing
- Reset values:
  - ig_rdy=1, eg_vld=0, eg_r*=0, mtx_cnt=0.
  - wr_sel=rd_sel=0, wr_col=rd_row=0, both full flags 0.
- Latency: eg_vld rises on the cycle after the third ingress beat of a matrix is accepted, i.e. 1 cycle after the last accept edge.
- Throughput: 3 beats/matrix each way. With eg_rdy=1 continuously, ingress is never stalled (zero bubbles).
- eg_vld deasserts in the cycle after the third egress transfer, unless the other bank is already full. In that case eg_vld stays 1 and the data switch banks.

## Configuration
- Macro: MAPU_MSTREAM_TRANSPOSER_STATS_EN.
- When defined:
  - Port mtx_cnt exists.
  - mtx_cnt increments on each egress rd_row==2 transfer.
  - It wraps from 16'hFFFF to 0 and resets to 0.
- When undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package mapu_mstream_tp_pkg holds:
  - localparam MSTREAM_ROWS=3
  - typedef for the 2-bit column/row index
  - typedef bank_t as a 3x3 array of DATA_WIDTH-wide elements (parameterized via a package-level max width)
- Sub-module mapu_mstream_tp_bank holds one 3x3 register bank:
  - column write port (we, col, 3 elements)
  - row read port (row → 3 elements)
  - full flag with set/clear inputs
  - instantiated twice

## Test plan
- Single matrix: ingress columns (1,4,7),(2,5,8),(3,6,9) with eg_rdy=1 → egress rows (1,2,3),(4,5,6),(7,8,9). eg_vld first high 1 cycle after the third accept.
- Back-to-back streaming: 8 matrices with ig_vld=1 and eg_rdy=1 throughout → ig_rdy never 0 after reset, 24 egress beats in order, mtx_cnt=8.
- Backpressure: eg_rdy=0, send 9 beats → first 6 accepted, ig_rdy=0 from the cycle after the 6th accept. Raise eg_rdy for 3 cycles → ig_rdy=1 the cycle after the 3rd egress transfer, 7th beat accepted.
- Random vld/rdy: ig_vld and eg_rdy each 50% random over 100 matrices with random data → scoreboard matches the transpose, with no lost or duplicated beats.
- Reset mid-matrix: accept 2 columns, assert reset_n=0 for 1 cycle → all outputs at reset values. A new full matrix then transposes correctly with no leftover columns.
- Counter wrap (STATS_EN): force mtx_cnt=16'hFFFF, complete one matrix → mtx_cnt=0.
